// File: rtl/exc_seq.sv
// Exception sequencer and CP0 register holder (SR, Cause, EPC, PRId).
// Sequences one-cycle flush/redirect episodes for exception entry and ERET.
module exc_seq #(
  parameter logic [31:0] HANDLER_ADDR = 32'h0000_4180,
  parameter logic [31:0] PRID         = 32'h0000_0001
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        exc_req,
  input  logic [4:0]  exc_code,
  input  logic [31:0] m_pc,
  input  logic        m_bd,
  input  logic        eret,
  input  logic [5:0]  hwint,
  input  logic        mtc0_we,
  input  logic [4:0]  cp0_addr,
  input  logic [31:0] cp0_wdata,
  output logic [31:0] cp0_rdata,
  output logic [31:0] sr,
  output logic [31:0] epc,
  output logic        flush,
  output logic        redirect,
  output logic [31:0] redirect_pc
);

  localparam logic [4:0] ADDR_SR    = 5'd12;
  localparam logic [4:0] ADDR_CAUSE = 5'd13;
  localparam logic [4:0] ADDR_EPC   = 5'd14;
  localparam logic [4:0] ADDR_PRID  = 5'd15;

  typedef enum logic [1:0] {RUN, ENTER, RETURN} state_t;

  state_t      state, state_nx;
  logic [5:0]  im, im_nx;
  logic        exl, exl_nx;
  logic        ie, ie_nx;
  logic [5:0]  ip, ip_nx;
  logic        bd, bd_nx;
  logic [4:0]  code, code_nx;
  logic [31:0] epc_nx;
  logic        flush_nx, redirect_nx;
  logic [31:0] redirect_pc_nx;
  logic [31:0] exc_pc;
  logic [31:0] cause;

  assign sr     = {16'h0000, im, 8'h00, exl, ie};
  assign cause  = {bd, 15'h0000, ip, 3'b000, code, 2'b00};
  // Delay-slot instructions restart at the branch; wraps modulo 2^32.
  assign exc_pc = m_bd ? (m_pc - 32'd4) : m_pc;

  always_comb begin
    case (cp0_addr)
      ADDR_SR:    cp0_rdata = sr;
      ADDR_CAUSE: cp0_rdata = cause;
      ADDR_EPC:   cp0_rdata = epc;
      ADDR_PRID:  cp0_rdata = PRID;
      default:    cp0_rdata = 32'h0000_0000;
    endcase
  end

  // Next-state and register-update logic; requests only act in RUN.
  always_comb begin
    state_nx       = RUN;
    im_nx          = im;
    exl_nx         = exl;
    ie_nx          = ie;
    ip_nx          = hwint;
    bd_nx          = bd;
    code_nx        = code;
    epc_nx         = epc;
    flush_nx       = 1'b0;
    redirect_nx    = 1'b0;
    redirect_pc_nx = redirect_pc;
    case (state)
      RUN: begin
        if (exc_req) begin
          code_nx        = exc_code;
          bd_nx          = m_bd;
          epc_nx         = exc_pc & 32'hFFFF_FFFC;
          exl_nx         = 1'b1;
          state_nx       = ENTER;
          flush_nx       = 1'b1;
          redirect_nx    = 1'b1;
          redirect_pc_nx = HANDLER_ADDR;
        end else if (eret) begin
          exl_nx         = 1'b0;
          state_nx       = RETURN;
          flush_nx       = 1'b1;
          redirect_nx    = 1'b1;
          redirect_pc_nx = epc;
        end else if (mtc0_we) begin
          case (cp0_addr)
            ADDR_SR: begin
              im_nx  = cp0_wdata[15:10];
              exl_nx = cp0_wdata[1];
              ie_nx  = cp0_wdata[0];
            end
            ADDR_EPC: epc_nx = {cp0_wdata[31:2], 2'b00};
            default: ;
          endcase
        end
      end
      default: state_nx = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= RUN;
      im          <= 6'd0;
      exl         <= 1'b0;
      ie          <= 1'b0;
      ip          <= 6'd0;
      bd          <= 1'b0;
      code        <= 5'd0;
      epc         <= 32'h0000_0000;
      flush       <= 1'b0;
      redirect    <= 1'b0;
      redirect_pc <= HANDLER_ADDR;
    end else begin
      state       <= state_nx;
      im          <= im_nx;
      exl         <= exl_nx;
      ie          <= ie_nx;
      ip          <= ip_nx;
      bd          <= bd_nx;
      code        <= code_nx;
      epc         <= epc_nx;
      flush       <= flush_nx;
      redirect    <= redirect_nx;
      redirect_pc <= redirect_pc_nx;
    end
  end

endmodule

// File: tb/tb_exc_seq.sv
// Bench for exc_seq: vector table through an expected-result queue, plus a reset-mid-episode sequence.
module tb_exc_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        exc_req;
  logic [4:0]  exc_code;
  logic [31:0] m_pc;
  logic        m_bd;
  logic        eret;
  logic [5:0]  hwint;
  logic        mtc0_we;
  logic [4:0]  cp0_addr;
  logic [31:0] cp0_wdata;
  logic [31:0] cp0_rdata;
  logic [31:0] sr;
  logic [31:0] epc;
  logic        flush;
  logic        redirect;
  logic [31:0] redirect_pc;

  exc_seq dut (
    .clk(clk), .reset(reset), .exc_req(exc_req), .exc_code(exc_code),
    .m_pc(m_pc), .m_bd(m_bd), .eret(eret), .hwint(hwint),
    .mtc0_we(mtc0_we), .cp0_addr(cp0_addr), .cp0_wdata(cp0_wdata),
    .cp0_rdata(cp0_rdata), .sr(sr), .epc(epc), .flush(flush),
    .redirect(redirect), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        exc_req;
    logic [4:0]  exc_code;
    logic [31:0] m_pc;
    logic        m_bd;
    logic        eret;
    logic [5:0]  hwint;
    logic        mtc0_we;
    logic [4:0]  cp0_addr;
    logic [31:0] cp0_wdata;
    logic        e_flush;
    logic        e_redirect;
    logic [31:0] e_rpc;
    logic [31:0] e_sr;
    logic [31:0] e_epc;
    logic [31:0] e_rdata;
  } vec_t;

  typedef struct {
    logic        flush;
    logic        redirect;
    logic [31:0] rpc;
    logic [31:0] sr;
    logic [31:0] epc;
    logic [31:0] rdata;
  } exp_t;

  vec_t vecs[$];
  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic er, input logic [4:0] ec, input logic [31:0] pc, input logic bd,
                     input logic et, input logic [5:0] hw, input logic we, input logic [4:0] ad,
                     input logic [31:0] wd, input logic fl, input logic rd, input logic [31:0] rpc,
                     input logic [31:0] s, input logic [31:0] e, input logic [31:0] rdat);
    vec_t v;
    v.exc_req = er; v.exc_code = ec; v.m_pc = pc; v.m_bd = bd; v.eret = et; v.hwint = hw;
    v.mtc0_we = we; v.cp0_addr = ad; v.cp0_wdata = wd;
    v.e_flush = fl; v.e_redirect = rd; v.e_rpc = rpc; v.e_sr = s; v.e_epc = e; v.e_rdata = rdat;
    vecs.push_back(v);
  endtask

  task automatic drive_idle();
    exc_req = 1'b0; exc_code = 5'd0; m_pc = 32'h0; m_bd = 1'b0; eret = 1'b0;
    hwint = 6'd0; mtc0_we = 1'b0; cp0_addr = 5'd0; cp0_wdata = 32'h0;
  endtask

  initial begin
    exp_t ex;
    drive_idle();
    reset = 1'b0;

    //   req code pc           bd eret hwint     we ad     wdata         fl rd rpc           sr            epc           rdata
    add(0, 5'd0,  32'h0,       0, 0, 6'b000000, 1, 5'd12, 32'hFFFF_FFFF, 0, 0, 32'h0000_4180, 32'h0000_FC03, 32'h0,        32'h0000_FC03);
    add(0, 5'd0,  32'h0,       0, 0, 6'b000000, 0, 5'd15, 32'h0,         0, 0, 32'h0000_4180, 32'h0000_FC03, 32'h0,        32'h0000_0001);
    add(0, 5'd0,  32'h0,       0, 0, 6'b000000, 1, 5'd15, 32'h0000_1234, 0, 0, 32'h0000_4180, 32'h0000_FC03, 32'h0,        32'h0000_0001);
    add(0, 5'd0,  32'h0,       0, 0, 6'b000000, 1, 5'd13, 32'hFFFF_FFFF, 0, 0, 32'h0000_4180, 32'h0000_FC03, 32'h0,        32'h0000_0000);
    add(0, 5'd0,  32'h0,       0, 0, 6'b000000, 1, 5'd14, 32'h1234_5677, 0, 0, 32'h0000_4180, 32'h0000_FC03, 32'h1234_5674, 32'h1234_5674);
    add(0, 5'd0,  32'h0,       0, 0, 6'b000000, 1, 5'd12, 32'h0000_0401, 0, 0, 32'h0000_4180, 32'h0000_0401, 32'h1234_5674, 32'h0000_0401);
    add(1, 5'd4,  32'h0000_3010, 0, 0, 6'b000000, 0, 5'd13, 32'h0,       1, 1, 32'h0000_4180, 32'h0000_0403, 32'h0000_3010, 32'h0000_0010);
    add(0, 5'd0,  32'h0,       0, 0, 6'b000000, 0, 5'd12, 32'h0,         0, 0, 32'h0000_4180, 32'h0000_0403, 32'h0000_3010, 32'h0000_0403);
    add(1, 5'd0,  32'h0000_3024, 1, 0, 6'b000000, 1, 5'd14, 32'hDEAD_BEEF, 1, 1, 32'h0000_4180, 32'h0000_0403, 32'h0000_3020, 32'h0000_3020);
    add(0, 5'd0,  32'h0,       0, 0, 6'b000000, 0, 5'd13, 32'h0,         0, 0, 32'h0000_4180, 32'h0000_0403, 32'h0000_3020, 32'h8000_0000);
    add(0, 5'd0,  32'h0,       0, 1, 6'b000000, 0, 5'd12, 32'h0,         1, 1, 32'h0000_3020, 32'h0000_0401, 32'h0000_3020, 32'h0000_0401);
    add(1, 5'd8,  32'h0000_5000, 0, 1, 6'b000000, 1, 5'd12, 32'h0,       0, 0, 32'h0000_3020, 32'h0000_0401, 32'h0000_3020, 32'h0000_0401);
    add(0, 5'd0,  32'h0,       0, 0, 6'b000000, 0, 5'd13, 32'h0,         0, 0, 32'h0000_3020, 32'h0000_0401, 32'h0000_3020, 32'h8000_0000);
    add(0, 5'd0,  32'h0,       0, 1, 6'b000000, 1, 5'd12, 32'h0,         1, 1, 32'h0000_3020, 32'h0000_0401, 32'h0000_3020, 32'h0000_0401);
    add(0, 5'd0,  32'h0,       0, 0, 6'b000100, 0, 5'd13, 32'h0,         0, 0, 32'h0000_3020, 32'h0000_0401, 32'h0000_3020, 32'h8000_1000);
    add(1, 5'd12, 32'h0,       1, 0, 6'b000100, 0, 5'd13, 32'h0,         1, 1, 32'h0000_4180, 32'h0000_0403, 32'hFFFF_FFFC, 32'h8000_1030);
    add(1, 5'd5,  32'h0000_0100, 0, 0, 6'b000010, 0, 5'd13, 32'h0,       0, 0, 32'h0000_4180, 32'h0000_0403, 32'hFFFF_FFFC, 32'h8000_0830);
    add(1, 5'd5,  32'h0000_0100, 0, 0, 6'b000010, 0, 5'd13, 32'h0,       1, 1, 32'h0000_4180, 32'h0000_0403, 32'h0000_0100, 32'h0000_0814);
    add(0, 5'd0,  32'h0,       0, 0, 6'b000000, 0, 5'd13, 32'h0,         0, 0, 32'h0000_4180, 32'h0000_0403, 32'h0000_0100, 32'h0000_0014);
    add(1, 5'd1,  32'h0000_2000, 0, 1, 6'b000000, 0, 5'd5,  32'h0,       1, 1, 32'h0000_4180, 32'h0000_0403, 32'h0000_2000, 32'h0000_0000);
    add(0, 5'd0,  32'h0,       0, 0, 6'b000000, 0, 5'd13, 32'h0,         0, 0, 32'h0000_4180, 32'h0000_0403, 32'h0000_2000, 32'h0000_0004);

    repeat (2) @(posedge clk);
    #1;
    chk("rst_flush", 32'(flush), 32'h0);
    chk("rst_redirect", 32'(redirect), 32'h0);
    chk("rst_rpc", redirect_pc, 32'h0000_4180);
    chk("rst_sr", sr, 32'h0);
    chk("rst_epc", epc, 32'h0);
    cp0_addr = 5'd13; #1;
    chk("rst_cause", cp0_rdata, 32'h0);
    cp0_addr = 5'd15; #1;
    chk("rst_prid", cp0_rdata, 32'h0000_0001);
    reset = 1'b1;

    foreach (vecs[i]) begin
      exc_req = vecs[i].exc_req; exc_code = vecs[i].exc_code; m_pc = vecs[i].m_pc;
      m_bd = vecs[i].m_bd; eret = vecs[i].eret; hwint = vecs[i].hwint;
      mtc0_we = vecs[i].mtc0_we; cp0_addr = vecs[i].cp0_addr; cp0_wdata = vecs[i].cp0_wdata;
      ex.flush = vecs[i].e_flush; ex.redirect = vecs[i].e_redirect; ex.rpc = vecs[i].e_rpc;
      ex.sr = vecs[i].e_sr; ex.epc = vecs[i].e_epc; ex.rdata = vecs[i].e_rdata;
      exp_q.push_back(ex);
      @(posedge clk);
      #1;
      ex = exp_q.pop_front();
      chk($sformatf("v%0d_flush", i), 32'(flush), 32'(ex.flush));
      chk($sformatf("v%0d_redirect", i), 32'(redirect), 32'(ex.redirect));
      chk($sformatf("v%0d_rpc", i), redirect_pc, ex.rpc);
      chk($sformatf("v%0d_sr", i), sr, ex.sr);
      chk($sformatf("v%0d_epc", i), epc, ex.epc);
      chk($sformatf("v%0d_rdata", i), cp0_rdata, ex.rdata);
    end

    // Reset pulsed during an ENTER cycle
    drive_idle();
    exc_req = 1'b1; exc_code = 5'd9; m_pc = 32'h0000_0080; cp0_addr = 5'd13;
    @(posedge clk);
    #1;
    chk("mid_flush_pre", 32'(flush), 32'h1);
    exc_req = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk("mid_flush_async", 32'(flush), 32'h0);
    chk("mid_redirect_async", 32'(redirect), 32'h0);
    chk("mid_sr", sr, 32'h0);
    chk("mid_epc", epc, 32'h0);
    chk("mid_cause", cp0_rdata, 32'h0);
    chk("mid_rpc", redirect_pc, 32'h0000_4180);
    #1 reset = 1'b1;
    @(posedge clk);
    #1;
    chk("post_flush", 32'(flush), 32'h0);
    chk("post_sr", sr, 32'h0);
    exc_req = 1'b1; exc_code = 5'd4; m_pc = 32'h0000_0040;
    @(posedge clk);
    #1;
    chk("post_exc_flush", 32'(flush), 32'h1);
    chk("post_exc_epc", epc, 32'h0000_0040);
    chk("post_exc_cause", cp0_rdata, 32'h0000_0010);
    drive_idle();
    @(posedge clk);
    #1;
    chk("post_exc_flush_drop", 32'(flush), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/exc_seq.md
# exc_seq

Exception sequencer and CP0 register holder for the pipelined MIPS core. It consumes the M-stage exception request and code produced by the exception/interrupt classifier. It owns SR, Cause, EPC and PRId, and feeds SR back to the classifier. It sequences exception entry and ERET return as fixed-length flush/redirect episodes toward the fetch stage and pipeline registers.

## Interface
- HANDLER_ADDR, 32'h0000_4180, exception/interrupt entry PC
- PRID, 32'h0000_0001, constant PRId (reg 15) value
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low; all state cleared while low
- exc_req  in  1  M-stage exception/interrupt request (classifier write-enable)
- exc_code  in  5  ExcCode; 0 = interrupt
- m_pc  in  32  PC of the M-stage instruction
- m_bd  in  1  M-stage instruction sits in a branch delay slot
- eret  in  1  ERET in M stage
- hwint  in  6  external interrupt lines
- mtc0_we  in  1  MTC0 write strobe (M stage)
- cp0_addr  in  5  register number for MTC0/MFC0
- cp0_wdata  in  32  MTC0 data
- cp0_rdata  out  32  MFC0 data, combinational on cp0_addr
- sr  out  32  current SR, to the classifier
- epc  out  32  current EPC
- flush  out  1  clear the F/D/E/M pipeline registers
- redirect  out  1  fetch loads redirect_pc
- redirect_pc  out  32  target PC

## Operation
- State register values: RUN, ENTER, RETURN. Reset state is RUN.
- Reset values:
  - sr, Cause and epc are 0.
  - flush and redirect are 0.
  - redirect_pc is HANDLER_ADDR.
- SR register:
  - Only bits [15:10] (IM), [1] (EXL) and [0] (IE) are stored.
  - All other bits read 0 and ignore writes.
- Cause register:
  - [15:10] IP is registered from hwint every cycle, including in ENTER and RETURN.
  - [6:2] holds ExcCode and [31] holds BD.
  - MTC0 to Cause is ignored.
- EPC register:
  - Bits [1:0] are forced to 0 on every write path.
  - MTC0 to reg 14 writes {cp0_wdata[31:2],2'b00}.
- MTC0 to reg 15 is ignored.
- MFC0 to any register other than 12–15 returns 0.
- RUN state, checked in priority order:
  - exc_req=1: latch ExcCode=exc_code and BD=m_bd. Latch EPC = m_bd ? m_pc−4 : m_pc (low 2 bits forced 0). Set EXL=1. Move to ENTER. A same-cycle MTC0 or eret is dropped.
  - else eret=1: clear EXL. Move to RETURN. A same-cycle MTC0 is dropped.
  - else mtc0_we=1: write the addressed register.
- ENTER state:
  - flush=1, redirect=1, redirect_pc=HANDLER_ADDR.
  - exc_req, eret and mtc0_we are ignored.
  - Next state is RUN.
- RETURN state:
  - flush=1, redirect=1, redirect_pc=epc (the value held at ERET).
  - exc_req, eret and mtc0_we are ignored.
  - Next state is RUN.
- Address arithmetic is 32-bit with modulo wrap: m_pc=0 with m_bd=1 gives EPC 0xFFFF_FFFC.
- No nesting: an exc_req arriving in RUN while EXL=1 is still honoured. EXL gating of interrupts happens in the classifier through sr.

## Timing
- Requests are sampled at rising edge T.
- flush and redirect are registered outputs. They are high for exactly the one cycle T→T+1. The core is back in RUN at T+1.
- SR, Cause and EPC updates are visible on sr, epc and cp0_rdata from T onward, the same cycle flush is high.
- Minimum spacing between two accepted episodes is 2 cycles.
- Back-to-back exc_req held high is re-accepted at T+1 in RUN.
- Reset asserted mid-episode:
  - flush and redirect drop asynchronously.
  - State returns to RUN and all registers return to 0.
  - The first edge after reset release samples inputs normally.

## Test plan
- Reset, then MTC0 reg 12 with 0xFFFF_FFFF → MFC0 reg 12 returns 0x0000_FC03. MFC0 reg 15 returns 0x0000_0001.
- exc_req=1, exc_code=4, m_pc=0x0000_3010, m_bd=0 → next cycle: flush=1, redirect=1, redirect_pc=0x0000_4180, epc=0x0000_3010, Cause[6:2]=4, SR[1]=1. Following cycle: flush=0.
- exc_req=1, exc_code=0, m_pc=0x0000_3024, m_bd=1, with a simultaneous MTC0 to EPC → epc=0x0000_3020, Cause[31]=1. The MTC0 has no effect.
- After entry, eret=1 → next cycle: redirect_pc=0x0000_3020, flush=1, SR[1]=0. An exc_req during the RETURN cycle is ignored.
- hwint=6'b000100 driven → Cause[15:10]=000100 one cycle later, also during an ENTER cycle.
- Reset pulsed low during ENTER → flush drops immediately. sr, epc and Cause read 0 after release.
